bridge_req_arbiter: RTL and testbench
=====================================

Name: bridge_req_arbiter

Overview:
Shares the single AHB-to-APB bridge packet interface between NUM_REQ AHB slave front-ends. Each front-end emits a 41-bit packet {write[40], wdata[39:8], addr[7:0]} with a one-cycle valid pulse. The block buffers one packet per requester and grants the bridge round-robin, one transfer at a time. It routes the bridge's write completion or read data back to the granted requester, with an optional response timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
TIMEOUT, 64, number of WAIT cycles without a bridge response before an error; 0 disables the timeout.
GW, $clog2(NUM_REQ), width of Grant_Id. Derived; not overridden.

Ports:
HCLK  in  1  clock; all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
Req_Packet  in  NUM_REQ*41  packet of requester i in bits [41*i+40 : 41*i].
Req_Valid  in  NUM_REQ  one-cycle pulse; captures the packet of requester i.
Req_Ready  out  NUM_REQ  one-cycle pulse; write of requester i completed.
Req_Rd_Valid  out  NUM_REQ  one-cycle pulse; Req_Rd_Data is valid for requester i.
Req_Rd_Data  out  32  read data, shared by all requesters.
Req_Err  out  NUM_REQ  one-cycle pulse; transfer of requester i timed out.
Req_Ovf  out  NUM_REQ  one-cycle pulse; packet of requester i dropped because its slot was full.
Packet_Out  out  41  packet issued to the bridge.
P_Valid  out  1  one-cycle pulse, coincident with a new Packet_Out.
Bridge_Ready  in  1  write-completion pulse from the bridge.
Bridge_Rd_Valid  in  1  read-data-valid pulse from the bridge.
Bridge_Rd_Data  in  32  read data from the bridge.
Grant_Id  out  GW  index of the current or last granted requester.
Busy  out  1  high while the state is ISSUE or WAIT.

Behaviour:
- Reset (synchronous, RESET=1 at an edge) sets:
  - all outputs to 0;
  - state = IDLE;
  - all pending flags and packet slots = 0;
  - round-robin pointer = NUM_REQ-1, so requester 0 wins first;
  - timeout counter = 0.
- Reset mid-transfer discards the transfer silently: no Ready, Rd_Valid or Err pulse.
- Capture:
  - Req_Valid[i]=1 with pend[i]=0: slot[i] <= packet, pend[i] <= 1.
  - Req_Valid[i]=1 with pend[i]=1 (not being issued this cycle): packet dropped, Req_Ovf[i] pulses next cycle.
  - Capture in the same cycle the slot is issued (state ISSUE, grant=i): the new packet is stored and pend[i] stays 1. The issued packet is the old one.
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE: if any pend bit is set, choose the first set bit scanning ptr+1, ptr+2, ... modulo NUM_REQ. Then grant <= index, ptr <= index, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: Packet_Out <= slot[grant], P_Valid <= 1 for one cycle, pend[grant] <= 0 (unless recaptured), counter <= 0, go to WAIT.
  - WAIT, write packet (bit 40 = 1): on Bridge_Ready, Req_Ready[grant] pulses, go to IDLE.
  - WAIT, read packet (bit 40 = 0): on Bridge_Rd_Valid, Req_Rd_Data <= Bridge_Rd_Data, Req_Rd_Valid[grant] pulses, go to IDLE.
  - WAIT, no valid response: counter increments. When TIMEOUT != 0 and counter == TIMEOUT-1, Req_Err[grant] pulses and the state goes to IDLE.
  - A valid response in the same cycle as the timeout takes priority; no Err pulse.
- Bridge_Ready or Bridge_Rd_Valid in IDLE or ISSUE is ignored. A mismatched response in WAIT (Rd_Valid on a write, Ready on a read) is ignored.
- Latency: Req_Valid in cycle 0 produces pend in cycle 1, ISSUE in cycle 2, and P_Valid high in cycle 3. A bridge response in cycle n produces the requester pulse and IDLE in cycle n+1. With back-to-back pending requests, issues are at least 3 cycles apart.
- Req_Rd_Data holds its value until the next read completes. Packet_Out holds its value until the next issue.
- Grant_Id holds the last grant. Busy = (state != IDLE).

Test Plan:
1. Write from requester 0: Req_Valid[0] in cycle 0 with {1, 0xDEADBEEF, 0x10}. Expect P_Valid in cycle 3 with Packet_Out = {1, 0xDEADBEEF, 0x10}. Bridge_Ready in cycle 5 -> Req_Ready[0] pulses in cycle 6; Busy falls in cycle 6.
2. Read from requester 1 at addr 0x24: Bridge_Rd_Valid with Bridge_Rd_Data = 0x12345678 -> Req_Rd_Valid[1] pulses with Req_Rd_Data = 0x12345678; Req_Rd_Valid[0] stays 0.
3. Fairness: Req_Valid to both requesters in the same cycle, repeated after every completion for 3 rounds. Expect grant order 0,1,0,1,0,1 and no starvation.
4. Timeout: TIMEOUT=8, no bridge response. Expect Req_Err[grant] 8 cycles after WAIT entry, then IDLE. A response exactly in that cycle must give Ready and no Err.
5. Overrun: two Req_Valid[1] pulses while requester 0 is in WAIT -> Req_Ovf[1] pulses once, and the first packet is issued.
6. Reset mid-WAIT: assert RESET for 1 cycle -> all outputs 0 and state IDLE; a late Bridge_Ready produces no Req_Ready pulse.

Source files
------------

// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge packet port among NUM_REQ front-ends.
// Each requester has one packet slot; the bridge's response is routed back to the granted requester.
module bridge_req_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int TIMEOUT = 64,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic [NUM_REQ*41-1:0] Req_Packet,
    input  logic [NUM_REQ-1:0]    Req_Valid,
    output logic [NUM_REQ-1:0]    Req_Ready,
    output logic [NUM_REQ-1:0]    Req_Rd_Valid,
    output logic [31:0]           Req_Rd_Data,
    output logic [NUM_REQ-1:0]    Req_Err,
    output logic [NUM_REQ-1:0]    Req_Ovf,
    output logic [40:0]           Packet_Out,
    output logic                  P_Valid,
    input  logic                  Bridge_Ready,
    input  logic                  Bridge_Rd_Valid,
    input  logic [31:0]           Bridge_Rd_Data,
    output logic [GW-1:0]         Grant_Id,
    output logic                  Busy
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;
    localparam int         CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef logic [40:0] pkt_t;

    logic [1:0]                state_q, state_d;
    logic [NUM_REQ-1:0]        pend_q, pend_d;
    logic [NUM_REQ-1:0][40:0]  slot_q, slot_d;
    logic [GW-1:0]             ptr_q, ptr_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    pkt_t                      pkt_q, pkt_d;
    logic [31:0]               rd_data_q, rd_data_d;
    logic                      p_valid_q, p_valid_d;
    logic [NUM_REQ-1:0]        ready_q, ready_d;
    logic [NUM_REQ-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_REQ-1:0]        err_q, err_d;
    logic [NUM_REQ-1:0]        ovf_q, ovf_d;
    logic                      found;
    int                        idx;
    logic [GW-1:0]             cand;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        pkt_d      = pkt_q;
        rd_data_d  = rd_data_q;
        p_valid_d  = 1'b0;
        ready_d    = '0;
        rd_valid_d = '0;
        err_d      = '0;
        ovf_d      = '0;
        found      = 1'b0;
        idx        = 0;
        cand       = '0;

        case (state_q)
            IDLE: begin
                // Scan starts just after the last winner so every requester gets a turn.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = int'(ptr_q) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    cand = GW'(idx);
                    if (!found && pend_q[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                        ptr_d   = cand;
                    end
                end
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                pkt_d           = slot_q[grant_q];
                p_valid_d       = 1'b1;
                pend_d[grant_q] = 1'b0;
                cnt_d           = '0;
                state_d         = WAIT;
            end
            WAIT: begin
                if (pkt_q[40] && Bridge_Ready) begin
                    ready_d[grant_q] = 1'b1;
                    state_d          = IDLE;
                end else if (!pkt_q[40] && Bridge_Rd_Valid) begin
                    rd_data_d           = Bridge_Rd_Data;
                    rd_valid_d[grant_q] = 1'b1;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                        err_d[grant_q] = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture after the FSM so a packet arriving while its slot issues re-arms pend.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Req_Valid[i]) begin
                if (!pend_q[i] || (state_q == ISSUE && grant_q == GW'(i))) begin
                    slot_d[i] = Req_Packet[41*i +: 41];
                    pend_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            slot_q     <= '0;
            ptr_q      <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            pkt_q      <= '0;
            rd_data_q  <= '0;
            p_valid_q  <= 1'b0;
            ready_q    <= '0;
            rd_valid_q <= '0;
            err_q      <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            slot_q     <= slot_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            pkt_q      <= pkt_d;
            rd_data_q  <= rd_data_d;
            p_valid_q  <= p_valid_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Req_Ready    = ready_q;
    assign Req_Rd_Valid = rd_valid_q;
    assign Req_Rd_Data  = rd_data_q;
    assign Req_Err      = err_q;
    assign Req_Ovf      = ovf_q;
    assign Packet_Out   = pkt_q;
    assign P_Valid      = p_valid_q;
    assign Grant_Id     = grant_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Directed bench for bridge_req_arbiter (2 requesters, TIMEOUT=8).
module tb_bridge_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int GW      = 1;

    logic                  HCLK = 1'b0;
    logic                  RESET;
    logic [NUM_REQ*41-1:0] Req_Packet;
    logic [NUM_REQ-1:0]    Req_Valid;
    logic [NUM_REQ-1:0]    Req_Ready, Req_Rd_Valid, Req_Err, Req_Ovf;
    logic [31:0]           Req_Rd_Data;
    logic [40:0]           Packet_Out;
    logic                  P_Valid;
    logic                  Bridge_Ready, Bridge_Rd_Valid;
    logic [31:0]           Bridge_Rd_Data;
    logic [GW-1:0]         Grant_Id;
    logic                  Busy;

    int n_chk = 0;
    int n_err = 0;

    bridge_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(8)) dut (
        .HCLK(HCLK), .RESET(RESET), .Req_Packet(Req_Packet), .Req_Valid(Req_Valid),
        .Req_Ready(Req_Ready), .Req_Rd_Valid(Req_Rd_Valid), .Req_Rd_Data(Req_Rd_Data),
        .Req_Err(Req_Err), .Req_Ovf(Req_Ovf), .Packet_Out(Packet_Out), .P_Valid(P_Valid),
        .Bridge_Ready(Bridge_Ready), .Bridge_Rd_Valid(Bridge_Rd_Valid),
        .Bridge_Rd_Data(Bridge_Rd_Data), .Grant_Id(Grant_Id), .Busy(Busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic [40:0] pk(input logic w, input logic [31:0] d, input logic [7:0] a);
        return {w, d, a};
    endfunction

    task automatic send(input int i, input logic [40:0] p);
        Req_Packet[41*i +: 41] = p;
        Req_Valid[i] = 1'b1;
        step();
        Req_Valid = '0;
    endtask

    task automatic wait_pv(input string tag);
        int c;
        c = 0;
        while (!P_Valid && c < 12) begin
            step();
            c++;
        end
        chk(tag, 64'(P_Valid), 64'd1);
    endtask

    task automatic resp_wr();
        Bridge_Ready = 1'b1;
        step();
        Bridge_Ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; Req_Packet = '0; Req_Valid = '0;
        Bridge_Ready = 1'b0; Bridge_Rd_Valid = 1'b0; Bridge_Rd_Data = '0;
        step(); step(); step();
        RESET = 1'b0;
        chk("rst_pv", 64'(P_Valid), 0);
        chk("rst_pkt", 64'(Packet_Out), 0);
        chk("rst_busy", 64'(Busy), 0);
        chk("rst_grant", 64'(Grant_Id), 0);
        chk("rst_pulses", 64'({Req_Ready, Req_Rd_Valid, Req_Err, Req_Ovf}), 0);
        chk("rst_rdata", 64'(Req_Rd_Data), 0);

        // 1: write from requester 0, exact latency
        send(0, pk(1'b1, 32'hDEADBEEF, 8'h10));            // cycle 1
        chk("t1_busy_c1", 64'(Busy), 0);
        step();                                             // cycle 2
        chk("t1_busy_c2", 64'(Busy), 1);
        chk("t1_pv_c2", 64'(P_Valid), 0);
        step();                                             // cycle 3
        chk("t1_pv_c3", 64'(P_Valid), 1);
        chk("t1_pkt", 64'(Packet_Out), 64'(pk(1'b1, 32'hDEADBEEF, 8'h10)));
        chk("t1_grant", 64'(Grant_Id), 0);
        step();                                             // cycle 4
        chk("t1_pv_c4", 64'(P_Valid), 0);
        step();                                             // cycle 5
        resp_wr();                                          // cycle 6
        chk("t1_ready", 64'(Req_Ready), 64'b01);
        chk("t1_busy_c6", 64'(Busy), 0);
        step();
        chk("t1_ready_off", 64'(Req_Ready), 0);
        chk("t1_pkt_hold", 64'(Packet_Out), 64'(pk(1'b1, 32'hDEADBEEF, 8'h10)));

        // 2: read from requester 1; mismatched Ready is ignored
        send(1, pk(1'b0, 32'h0, 8'h24));
        step(); step();                                     // cycle 3
        chk("t2_pv", 64'(P_Valid), 1);
        chk("t2_pkt", 64'(Packet_Out), 64'(pk(1'b0, 32'h0, 8'h24)));
        chk("t2_grant", 64'(Grant_Id), 1);
        Bridge_Ready = 1'b1;
        step();                                             // cycle 4
        Bridge_Ready = 1'b0;
        chk("t2_mismatch_ready", 64'(Req_Ready), 0);
        chk("t2_mismatch_busy", 64'(Busy), 1);
        Bridge_Rd_Valid = 1'b1; Bridge_Rd_Data = 32'h12345678;
        step();                                             // cycle 5
        Bridge_Rd_Valid = 1'b0; Bridge_Rd_Data = 32'hFFFF0000;
        chk("t2_rdv", 64'(Req_Rd_Valid), 64'b10);
        chk("t2_rdata", 64'(Req_Rd_Data), 64'h12345678);
        chk("t2_busy", 64'(Busy), 0);
        step();
        chk("t2_rdv_off", 64'(Req_Rd_Valid), 0);
        chk("t2_rdata_hold", 64'(Req_Rd_Data), 64'h12345678);

        // 3: fairness, both request together for 3 rounds
        for (int r = 0; r < 3; r++) begin
            Req_Packet[0 +: 41]  = pk(1'b1, 32'hA000_0000 + r, 8'h40);
            Req_Packet[41 +: 41] = pk(1'b1, 32'hB000_0000 + r, 8'h80);
            Req_Valid = 2'b11;
            step();
            Req_Valid = '0;
            wait_pv($sformatf("t3_pv0_r%0d", r));
            chk($sformatf("t3_grant0_r%0d", r), 64'(Grant_Id), 0);
            chk($sformatf("t3_pkt0_r%0d", r), 64'(Packet_Out), 64'(pk(1'b1, 32'hA000_0000 + r, 8'h40)));
            resp_wr();
            chk($sformatf("t3_rdy0_r%0d", r), 64'(Req_Ready), 64'b01);
            wait_pv($sformatf("t3_pv1_r%0d", r));
            chk($sformatf("t3_grant1_r%0d", r), 64'(Grant_Id), 1);
            chk($sformatf("t3_pkt1_r%0d", r), 64'(Packet_Out), 64'(pk(1'b1, 32'hB000_0000 + r, 8'h80)));
            resp_wr();
            chk($sformatf("t3_rdy1_r%0d", r), 64'(Req_Ready), 64'b10);
            step();
        end

        // 4a: timeout, Err 8 cycles after WAIT entry
        send(0, pk(1'b1, 32'h0BAD0BAD, 8'h01));
        step(); step();                                     // cycle 3, WAIT entry
        chk("t4_pv", 64'(P_Valid), 1);
        for (int k = 0; k < 7; k++) step();                 // cycle 10
        chk("t4_err_early", 64'(Req_Err), 0);
        chk("t4_busy_c10", 64'(Busy), 1);
        step();                                             // cycle 11
        chk("t4_err", 64'(Req_Err), 64'b01);
        chk("t4_busy_c11", 64'(Busy), 0);
        step();
        chk("t4_err_off", 64'(Req_Err), 0);

        // 4b: response in the timeout cycle wins
        send(1, pk(1'b1, 32'h600D600D, 8'h02));
        step(); step();                                     // cycle 3
        chk("t4b_grant", 64'(Grant_Id), 1);
        for (int k = 0; k < 7; k++) step();                 // cycle 10
        resp_wr();                                          // cycle 11
        chk("t4b_ready", 64'(Req_Ready), 64'b10);
        chk("t4b_no_err", 64'(Req_Err), 0);
        chk("t4b_busy", 64'(Busy), 0);

        // 5: overrun on requester 1 while requester 0 waits
        step();
        send(0, pk(1'b1, 32'h11111111, 8'h03));
        step(); step();                                     // cycle 3, WAIT
        Req_Packet[41 +: 41] = pk(1'b1, 32'hAAAAAAAA, 8'h0A);
        Req_Valid = 2'b10;
        step();                                             // cycle 4
        chk("t5_ovf_c4", 64'(Req_Ovf), 0);
        Req_Packet[41 +: 41] = pk(1'b1, 32'hBBBBBBBB, 8'h0B);
        step();                                             // cycle 5
        Req_Valid = '0;
        chk("t5_ovf_c5", 64'(Req_Ovf), 64'b10);
        step();                                             // cycle 6
        chk("t5_ovf_c6", 64'(Req_Ovf), 0);
        resp_wr();
        chk("t5_ready0", 64'(Req_Ready), 64'b01);
        wait_pv("t5_pv1");
        chk("t5_grant1", 64'(Grant_Id), 1);
        chk("t5_pkt_first", 64'(Packet_Out), 64'(pk(1'b1, 32'hAAAAAAAA, 8'h0A)));
        resp_wr();
        chk("t5_ready1", 64'(Req_Ready), 64'b10);

        // 5b: capture during ISSUE of the same slot stores the new packet
        send(1, pk(1'b1, 32'hD0D0D0D0, 8'h0D));            // cycle 1
        step();                                             // cycle 2, ISSUE
        Req_Packet[41 +: 41] = pk(1'b1, 32'hE0E0E0E0, 8'h0E);
        Req_Valid = 2'b10;
        step();                                             // cycle 3
        Req_Valid = '0;
        chk("t5b_pv", 64'(P_Valid), 1);
        chk("t5b_pkt_old", 64'(Packet_Out), 64'(pk(1'b1, 32'hD0D0D0D0, 8'h0D)));
        chk("t5b_no_ovf", 64'(Req_Ovf), 0);
        resp_wr();
        chk("t5b_ready", 64'(Req_Ready), 64'b10);
        wait_pv("t5b_pv2");
        chk("t5b_pkt_new", 64'(Packet_Out), 64'(pk(1'b1, 32'hE0E0E0E0, 8'h0E)));
        resp_wr();

        // 6: reset mid-WAIT, late Ready is ignored
        step();
        send(0, pk(1'b1, 32'hCAFEF00D, 8'h55));
        wait_pv("t6_pv");
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("t6_busy", 64'(Busy), 0);
        chk("t6_pkt", 64'(Packet_Out), 0);
        chk("t6_grant", 64'(Grant_Id), 0);
        chk("t6_rdata", 64'(Req_Rd_Data), 0);
        chk("t6_pulses", 64'({Req_Ready, Req_Rd_Valid, Req_Err, Req_Ovf, P_Valid}), 0);
        resp_wr();
        chk("t6_no_ready", 64'(Req_Ready), 0);
        chk("t6_idle", 64'(Busy), 0);
        step();
        chk("t6_no_issue", 64'(P_Valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
